pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf.sv | 112 +++++++++++
 tb/tb_pipe_stage_buf.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer between two valid/ready stages (e.g. IF/ID: PC+4 and instruction).
// SKID=1 gives a two-entry skid buffer with registered in_ready; SKID=0 a single register.
module pipe_stage_buf #(
   parameter int               WIDTH  = 64,
   parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
   parameter int               SKID   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   input  logic             flush,
   output logic [1:0]       count
);

   // Handshake: a beat moves on a rising edge where valid & ready are both high;
   // once out_valid is high, out_valid/out_data hold until out_ready is seen.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] md_q, md_d;
   logic [WIDTH-1:0] sd_q, sd_d;
   logic [1:0]       count_q, count_d;
   logic             in_ready_q, in_ready_d;
   logic             mv;
   logic             accept;
   logic             deliver;

   assign mv        = (state_q != EMPTY);
   assign out_valid = mv;
   assign out_data  = mv ? md_q : BUBBLE;
   assign in_ready  = (SKID != 0) ? in_ready_q : (~mv | out_ready);
   assign accept    = in_valid & in_ready;
   assign deliver   = mv & out_ready;
   assign count     = count_q;

   always_comb begin
      state_d = state_q;
      md_d    = md_q;
      sd_d    = sd_q;
      if (flush) begin
         state_d = EMPTY;
         md_d    = BUBBLE;
         sd_d    = BUBBLE;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  md_d    = in_data;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (accept && deliver) begin
                  md_d = in_data;
               end else if (deliver) begin
                  state_d = EMPTY;
               end else if (accept && (SKID != 0)) begin
                  sd_d    = in_data;
                  state_d = FULL;
               end
            end
            FULL: begin
               // in_ready is low here, so only a delivery can move the state
               if (deliver) begin
                  md_d    = sd_q;
                  sd_d    = BUBBLE;
                  state_d = ONE;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   always_comb begin
      count_d = 2'd0;
      case (state_d)
         ONE:     count_d = 2'd1;
         FULL:    count_d = 2'd2;
         default: count_d = 2'd0;
      endcase
      in_ready_d = (state_d != FULL);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= EMPTY;
         md_q       <= BUBBLE;
         sd_q       <= BUBBLE;
         count_q    <= 2'd0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         md_q       <= md_d;
         sd_q       <= sd_d;
         count_q    <= count_d;
         in_ready_q <= in_ready_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a SKID=1 instance driven from a vector table plus
// hand sequences, and a SKID=0 instance checked against an expected-data queue.
module tb_pipe_stage_buf;

   localparam int W = 64;

   logic         clk;
   logic         reset;

   logic         iv1, ir1, ov1, or1, fl1;
   logic [W-1:0] id1, od1;
   logic [1:0]   cnt1;

   logic         iv0, ir0, ov0, or0, fl0;
   logic [W-1:0] id0, od0;
   logic [1:0]   cnt0;

   int checks;
   int failures;

   logic [W-1:0] exp_q[$];

   typedef struct {
      logic         iv;
      logic [W-1:0] d;
      logic         ordy;
      logic         fl;
      logic         e_ov;
      logic [W-1:0] e_od;
      logic         e_ir;
      logic [1:0]   e_cnt;
   } vec_t;

   vec_t vecs[15];

   pipe_stage_buf #(.WIDTH(W), .SKID(1)) dut (
      .clk(clk), .reset(reset),
      .in_valid(iv1), .in_data(id1), .in_ready(ir1),
      .out_valid(ov1), .out_data(od1), .out_ready(or1),
      .flush(fl1), .count(cnt1)
   );

   pipe_stage_buf #(.WIDTH(W), .SKID(0)) dut0 (
      .clk(clk), .reset(reset),
      .in_valid(iv0), .in_data(id0), .in_ready(ir0),
      .out_valid(ov0), .out_data(od0), .out_ready(or0),
      .flush(fl0), .count(cnt0)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
      iv1 = iv;
      id1 = d;
      or1 = ordy;
      fl1 = fl;
   endtask

   task automatic check1(input string tag, input logic e_ov, input logic [W-1:0] e_od,
                         input logic e_ir, input logic [1:0] e_cnt);
      check({tag, " out_valid"}, W'(ov1), W'(e_ov));
      check({tag, " out_data"}, od1, e_od);
      check({tag, " in_ready"}, W'(ir1), W'(e_ir));
      check({tag, " count"}, W'(cnt1), W'(e_cnt));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      drive1(1'b0, '0, 1'b1, 1'b0);
      iv0 = 1'b0; id0 = '0; or0 = 1'b1; fl0 = 1'b0;

      // rows: {in_valid, in_data, out_ready, flush, exp out_valid, out_data, in_ready, count}
      vecs[0]  = '{1'b1, 64'h00000004_20080001, 1'b1, 1'b0, 1'b1, 64'h00000004_20080001, 1'b1, 2'd1};
      vecs[1]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 2'd0};
      vecs[2]  = '{1'b1, 64'h1, 1'b0, 1'b0, 1'b1, 64'h1, 1'b1, 2'd1};
      vecs[3]  = '{1'b1, 64'h2, 1'b0, 1'b0, 1'b1, 64'h1, 1'b0, 2'd2};
      vecs[4]  = '{1'b1, 64'h3, 1'b0, 1'b0, 1'b1, 64'h1, 1'b0, 2'd2};
      vecs[5]  = '{1'b1, 64'h3, 1'b1, 1'b0, 1'b1, 64'h2, 1'b1, 2'd1};
      vecs[6]  = '{1'b1, 64'h3, 1'b1, 1'b0, 1'b1, 64'h3, 1'b1, 2'd1};
      vecs[7]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 2'd0};
      vecs[8]  = '{1'b1, 64'h5, 1'b0, 1'b0, 1'b1, 64'h5, 1'b1, 2'd1};
      vecs[9]  = '{1'b1, 64'h6, 1'b0, 1'b0, 1'b1, 64'h5, 1'b0, 2'd2};
      vecs[10] = '{1'b1, 64'h7, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 2'd0};
      vecs[11] = '{1'b1, 64'h8, 1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 2'd0};
      vecs[12] = '{1'b1, 64'h9, 1'b1, 1'b0, 1'b1, 64'h9, 1'b1, 2'd1};
      vecs[13] = '{1'b0, 64'hdead, 1'b0, 1'b0, 1'b1, 64'h9, 1'b1, 2'd1};
      vecs[14] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 2'd0};

      // reset values, no clock edge yet
      #2;
      check1("reset", 1'b0, '0, 1'b1, 2'd0);
      check("reset skid0 out_valid", W'(ov0), W'(1'b0));
      check("reset skid0 in_ready", W'(ir0), W'(1'b1));
      check("reset skid0 count", W'(cnt0), W'(2'd0));
      step();
      reset = 1'b0;

      // vector table on the SKID=1 instance
      for (int i = 0; i < 15; i++) begin
         drive1(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
         step();
         check1($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od, vecs[i].e_ir, vecs[i].e_cnt);
      end

      // async reset in FULL, between edges
      drive1(1'b1, 64'h11, 1'b0, 1'b0);
      step();
      drive1(1'b1, 64'h22, 1'b0, 1'b0);
      step();
      check1("pre_areset", 1'b1, 64'h11, 1'b0, 2'd2);
      #2;
      reset = 1'b1;
      #1;
      check1("areset", 1'b0, '0, 1'b1, 2'd0);
      drive1(1'b0, '0, 1'b1, 1'b0);
      #1;
      reset = 1'b0;
      drive1(1'b1, 64'h33, 1'b1, 1'b0);
      step();
      check1("first_accept", 1'b1, 64'h33, 1'b1, 2'd1);
      drive1(1'b0, '0, 1'b1, 1'b0);
      step();
      check1("drain", 1'b0, '0, 1'b1, 2'd0);

      // idle with out_ready toggling
      for (int i = 0; i < 10; i++) begin
         drive1(1'b0, 64'(32'hbeef0000 + i), (i % 2) == 0, 1'b0);
         step();
         check(" idle out_valid", W'(ov1), W'(1'b0));
         check("idle out_data", od1, '0);
         check("idle count", W'(cnt1), W'(2'd0));
      end

      // SKID=0: combinational in_ready and full-rate streaming
      iv0 = 1'b1; id0 = 64'h100; or0 = 1'b0;
      step();
      exp_q.push_back(64'h100);
      check("s0 load out_valid", W'(ov0), W'(1'b1));
      check("s0 in_ready held", W'(ir0), W'(1'b0));
      id0 = 64'h101;
      step();
      check("s0 no full count", W'(cnt0), W'(2'd1));
      check("s0 hold data", od0, 64'h100);
      or0 = 1'b1;
      #1;
      check("s0 in_ready comb", W'(ir0), W'(1'b1));
      for (int k = 0; k < 8; k++) begin
         id0 = 64'h200 + 64'(k);
         #1;
         check("s0 stream out_valid", W'(ov0), W'(1'b1));
         check("s0 stream data", od0, exp_q.pop_front());
         exp_q.push_back(id0);
         step();
         check("s0 stream count", W'(cnt0), W'(2'd1));
      end
      iv0 = 1'b0;
      #1;
      check("s0 last data", od0, exp_q.pop_front());
      step();
      check("s0 drained out_valid", W'(ov0), W'(1'b0));
      check("s0 drained count", W'(cnt0), W'(2'd0));
      check("s0 queue empty", W'(exp_q.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
